// File: rtl/pll_reset_sequencer_if.sv
// Pixel-domain reset sequencer signal bundle: lock/button inputs and reset/status outputs.
// The lock_loss_cnt member exists only when LOCK_LOSS_COUNT_EN is defined.
interface pll_reset_sequencer_if;
    logic       lock_in;
    logic       btn_n;
    logic       rst_out;
    logic       rst_n_out;
    logic       ready;
    logic [1:0] state;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt;

    modport master (
        output lock_in,
        output btn_n,
        input  rst_out,
        input  rst_n_out,
        input  ready,
        input  state,
        input  lock_loss_cnt
    );

    modport slave (
        input  lock_in,
        input  btn_n,
        output rst_out,
        output rst_n_out,
        output ready,
        output state,
        output lock_loss_cnt
    );
`else
    modport master (
        output lock_in,
        output btn_n,
        input  rst_out,
        input  rst_n_out,
        input  ready,
        input  state
    );

    modport slave (
        input  lock_in,
        input  btn_n,
        output rst_out,
        output rst_n_out,
        output ready,
        output state
    );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// Clean pixel-domain reset: waits for a stable PLL lock, re-asserts on lock loss or button press.
// Optional saturating lock-loss counter is enabled by defining LOCK_LOSS_COUNT_EN.
module pll_reset_sequencer #(
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_reset_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b01,
        SETTLE    = 2'b10,
        RUN       = 2'b11
    } state_t;

    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic            lock_p0;
    logic            lock_s;
    logic            btn_p0;
    logic            btn_p1;
    logic            btn_raw;
    logic            btn_db;
    logic [DB_W-1:0] db_cnt;

    state_t          state_q;
    state_t          state_d;
    logic [ST_W-1:0] st_cnt_q;
    logic [ST_W-1:0] st_cnt_d;
    logic            lock_loss;

    logic            rst_out_q;
    logic            rst_n_out_q;
    logic            ready_q;

    // Stage p0/p1: two-flop synchronisers; button idles released (high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
            btn_p0  <= 1'b1;
            btn_p1  <= 1'b1;
        end else begin
            lock_p0 <= bus.lock_in;
            lock_s  <= lock_p0;
            btn_p0  <= bus.btn_n;
            btn_p1  <= btn_p0;
        end
    end

    assign btn_raw = ~btn_p1;

    // Debounce: btn_db follows btn_raw only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_raw == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_raw;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_ONE;
        end
    end

    // Lock loss outranks a simultaneous button press when leaving RUN
    assign lock_loss = (state_q == RUN) && !lock_s;

    always_comb begin
        state_d  = state_q;
        st_cnt_d = st_cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s && !btn_db) begin
                    state_d  = SETTLE;
                    st_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (!lock_s || btn_db) begin
                    state_d = WAIT_LOCK;
                end else if (st_cnt_q == ST_LAST) begin
                    state_d = RUN;
                end else begin
                    st_cnt_d = st_cnt_q + ST_ONE;
                end
            end
            RUN: begin
                if (lock_loss || btn_db) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // Outputs are registered from next-state so they move on the same edge as state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            st_cnt_q    <= '0;
            rst_out_q   <= 1'b1;
            rst_n_out_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_cnt_q    <= st_cnt_d;
            rst_out_q   <= (state_d != RUN);
            rst_n_out_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign bus.state     = state_q;
    assign bus.rst_out   = rst_out_q;
    assign bus.rst_n_out = rst_n_out_q;
    assign bus.ready     = ready_q;

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt_q <= 8'h00;
        end else if (lock_loss && (lock_loss_cnt_q != 8'hFF)) begin
            lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
        end
    end

    assign bus.lock_loss_cnt = lock_loss_cnt_q;
`endif

endmodule
